// File: rtl/val2_shifter_pipe.sv
// val2_shifter_pipe: pipelined ARM operand-2 (Val2) generator with shifter carry-out.
// Valid/ready handshake, stall and flush. Macro VAL2_REG_SHIFT_EN enables register-specified shifts.
module val2_shifter_pipe #(
    parameter int DATA_W     = 32,
    parameter int PIPE_DEPTH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [7:0]        val_rs,
    input  logic [11:0]       shift_operand,
    input  logic              imm,
    input  logic              mem_rw,
    input  logic              reg_shift,
    input  logic              carry_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] val2,
    output logic              shift_carry_out
);

    localparam int LW    = $clog2(DATA_W);
    localparam int AMT_W = LW + 1;
    localparam logic [7:0]       DW8    = 8'(DATA_W);
    localparam logic [AMT_W-1:0] DW_AMT = AMT_W'(DATA_W);

    localparam logic [2:0] OP_PASS = 3'd0;
    localparam logic [2:0] OP_LSL  = 3'd1;
    localparam logic [2:0] OP_LSR  = 3'd2;
    localparam logic [2:0] OP_ASR  = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;
    localparam logic [2:0] OP_RRX  = 3'd5;
    localparam logic [2:0] OP_ZERO = 3'd6;

    localparam logic [1:0] SH_LSL = 2'd0;
    localparam logic [1:0] SH_LSR = 2'd1;
    localparam logic [1:0] SH_ASR = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    // Executes a decoded shift; amt is already clamped to 0..DATA_W. Returns {carry, value}.
    function automatic logic [DATA_W:0] f_exec(
        input logic [2:0]        op,
        input logic [DATA_W-1:0] src,
        input logic [AMT_W-1:0]  amt,
        input logic              cin
    );
        logic [DATA_W-1:0] v;
        logic              c;
        logic [LW-1:0]     i_hi;
        logic [LW-1:0]     i_lo;
        i_hi = LW'(DW_AMT - amt);
        i_lo = LW'(amt - AMT_W'(1));
        v    = src;
        c    = cin;
        case (op)
            OP_PASS: begin v = src; c = cin; end
            OP_LSL:  begin v = src << amt; c = src[i_hi]; end
            OP_LSR:  begin v = src >> amt; c = src[i_lo]; end
            OP_ASR:  begin v = $unsigned($signed(src) >>> amt); c = src[i_lo]; end
            OP_ROR:  begin
                v = (src >> amt) | (src << (DW_AMT - amt));
                c = v[DATA_W-1];
            end
            OP_RRX:  begin v = {cin, src[DATA_W-1:1]}; c = src[0]; end
            OP_ZERO: begin v = {DATA_W{1'b0}}; c = 1'b0; end
            default: begin v = src; c = cin; end
        endcase
        return {c, v};
    endfunction

    logic              w_is_reg;
    logic [7:0]        w_amt8;
    logic [LW-1:0]     w_rot;
    logic [2:0]        w_op;
    logic [DATA_W-1:0] w_src;
    logic [AMT_W-1:0]  w_amt;
    logic              w_adv_out;
    logic              w_adv_in;
    logic              w_pre_v;
    logic [DATA_W:0]   w_res;

    logic              r_out_v;
    logic [DATA_W-1:0] r_val2;
    logic              r_c;

`ifdef VAL2_REG_SHIFT_EN
    assign w_is_reg = reg_shift;
    assign w_amt8   = reg_shift ? val_rs : {3'b000, shift_operand[11:7]};
`else
    assign w_is_reg = 1'b0;
    assign w_amt8   = {3'b000, shift_operand[11:7]};
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, reg_shift, val_rs};
`endif

    // Immediate rotate is twice the 4-bit field, taken modulo the datapath width.
    assign w_rot = LW'({shift_operand[11:8], 1'b0});

    // Operand-2 form decode: selects source, operation and clamped effective amount.
    always_comb begin
        w_op  = OP_PASS;
        w_src = val_rm;
        w_amt = {AMT_W{1'b0}};
        if (mem_rw) begin
            w_src = {{(DATA_W-12){1'b0}}, shift_operand[11:0]};
        end else if (imm) begin
            w_src = {{(DATA_W-8){1'b0}}, shift_operand[7:0]};
            w_amt = {1'b0, w_rot};
            if (w_rot != {LW{1'b0}}) begin
                w_op = OP_ROR;
            end else begin
                w_op = OP_PASS;
            end
        end else if (w_amt8 == 8'd0) begin
            if (w_is_reg) begin
                w_op = OP_PASS;
            end else begin
                case (shift_operand[6:5])
                    SH_LSL:  w_op = OP_PASS;
                    SH_LSR:  begin w_op = OP_LSR; w_amt = DW_AMT; end
                    SH_ASR:  begin w_op = OP_ASR; w_amt = DW_AMT; end
                    SH_ROR:  w_op = OP_RRX;
                    default: w_op = OP_PASS;
                endcase
            end
        end else begin
            case (shift_operand[6:5])
                SH_LSL: begin
                    if (w_amt8 > DW8) begin
                        w_op = OP_ZERO;
                    end else begin
                        w_op  = OP_LSL;
                        w_amt = w_amt8[AMT_W-1:0];
                    end
                end
                SH_LSR: begin
                    if (w_amt8 > DW8) begin
                        w_op = OP_ZERO;
                    end else begin
                        w_op  = OP_LSR;
                        w_amt = w_amt8[AMT_W-1:0];
                    end
                end
                SH_ASR: begin
                    w_op  = OP_ASR;
                    w_amt = (w_amt8 >= DW8) ? DW_AMT : w_amt8[AMT_W-1:0];
                end
                SH_ROR: begin
                    w_op  = OP_ROR;
                    w_amt = {1'b0, w_amt8[LW-1:0]};
                end
                default: w_op = OP_PASS;
            endcase
        end
    end

    assign w_adv_out = !r_out_v || out_ready;
    assign in_ready  = !rst && !flush && w_adv_in;

    generate
        if (PIPE_DEPTH == 1) begin : g_d1
            assign w_adv_in = w_adv_out;
            assign w_pre_v  = in_valid;
            assign w_res    = f_exec(w_op, w_src, w_amt, carry_in);
        end else begin : g_d2
            logic              r_d_v;
            logic [2:0]        r_d_op;
            logic [DATA_W-1:0] r_d_src;
            logic [AMT_W-1:0]  r_d_amt;
            logic              r_d_cin;

            assign w_adv_in = !r_d_v || w_adv_out;
            assign w_pre_v  = r_d_v;
            assign w_res    = f_exec(r_d_op, r_d_src, r_d_amt, r_d_cin);

            // Decode stage: holds the selected form, source, amount and carry-in.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_d_v   <= 1'b0;
                    r_d_op  <= OP_PASS;
                    r_d_src <= {DATA_W{1'b0}};
                    r_d_amt <= {AMT_W{1'b0}};
                    r_d_cin <= 1'b0;
                end else if (flush) begin
                    r_d_v <= 1'b0;
                end else if (w_adv_in) begin
                    r_d_v <= in_valid;
                    if (in_valid) begin
                        r_d_op  <= w_op;
                        r_d_src <= w_src;
                        r_d_amt <= w_amt;
                        r_d_cin <= carry_in;
                    end
                end
            end
        end
    endgenerate

    // Result stage: captures shifted value and carry; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_v <= 1'b0;
            r_val2  <= {DATA_W{1'b0}};
            r_c     <= 1'b0;
        end else if (flush) begin
            r_out_v <= 1'b0;
        end else if (w_adv_out) begin
            r_out_v <= w_pre_v;
            if (w_pre_v) begin
                r_val2 <= w_res[DATA_W-1:0];
                r_c    <= w_res[DATA_W];
            end
        end
    end

    assign out_valid       = r_out_v;
    assign val2            = r_val2;
    assign shift_carry_out = r_c;

endmodule

// File: tb/tb_val2_shifter_pipe.sv
// Self-checking bench for val2_shifter_pipe (DATA_W=32, PIPE_DEPTH=2) with a behavioural
// reference model and a queue-based scoreboard.
module tb_val2_shifter_pipe;

    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready;
    logic [DW-1:0] val_rm;
    logic [7:0]    val_rs;
    logic [11:0]   shift_operand;
    logic          imm, mem_rw, reg_shift, carry_in;
    logic          out_valid, out_ready;
    logic [DW-1:0] val2;
    logic          shift_carry_out;

    int n_cmp  = 0;
    int n_fail = 0;
    logic        last_acc;
    logic [32:0] exp_q[$];
    logic [33:0] got_q[$];
    logic [33:0] cmp_q[$];

    val2_shifter_pipe #(.DATA_W(DW), .PIPE_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .val_rm(val_rm), .val_rs(val_rs), .shift_operand(shift_operand), .imm(imm),
        .mem_rw(mem_rw), .reg_shift(reg_shift), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready), .val2(val2),
        .shift_carry_out(shift_carry_out)
    );

    always #5 clk = ~clk;

    // Reference: ARM operand-2 rules with wide arithmetic; carry = last bit shifted out.
    function automatic logic [32:0] ref_model(input logic [31:0] rm, input logic [7:0] rs,
                                              input logic [11:0] so, input logic im,
                                              input logic mem, input logic rsh, input logic cin);
        logic [63:0] w;
        logic [31:0] x;
        logic        use_reg;
        int          n, r;
        if (mem) return {cin, 20'h0, so};
        if (im) begin
            r = (int'(so[11:8]) * 2) % 32;
            x = {24'h0, so[7:0]};
            w = {x, x} >> r;
            return {(r == 0) ? cin : w[31], w[31:0]};
        end
`ifdef VAL2_REG_SHIFT_EN
        use_reg = rsh;
`else
        use_reg = 1'b0;
`endif
        n = use_reg ? int'(rs) : int'(so[11:7]);
        if (n == 0 && use_reg) return {cin, rm};
        case (so[6:5])
            2'd0: begin
                if (n == 0) return {cin, rm};
                w = {32'h0, rm} << n;
                return {w[32], w[31:0]};
            end
            2'd1: begin
                if (n == 0) n = 32;
                w = {rm, 32'h0} >> n;
                return {w[31], w[63:32]};
            end
            2'd2: begin
                if (n == 0) n = 32;
                w = $signed({rm, 32'h0}) >>> n;
                return {w[31], w[63:32]};
            end
            default: begin
                if (n == 0) return {rm[0], cin, rm[31:1]};
                r = n % 32;
                w = {rm, rm} >> r;
                return {w[31], w[31:0]};
            end
        endcase
    endfunction

    // One clock: record accepts and output handshakes into the scoreboard queues.
    task automatic tick();
        logic acc, ohs;
        logic [32:0] gv, ev;
        #1;
        acc = in_valid && in_ready && !flush && !rst;
        ohs = out_valid && out_ready && !flush && !rst;
        gv  = {shift_carry_out, val2};
        ev  = ref_model(val_rm, val_rs, shift_operand, imm, mem_rw, reg_shift, carry_in);
        @(posedge clk);
        if (ohs) begin
            got_q.push_back({1'b0, gv});
            if (exp_q.size() > 0) cmp_q.push_back({1'b0, exp_q.pop_front()});
            else cmp_q.push_back({1'b1, 33'h0});
        end
        if (rst || flush) exp_q.delete();
        else if (acc) exp_q.push_back(ev);
        last_acc = acc;
        @(negedge clk);
    endtask

    task automatic clear_sb();
        exp_q.delete(); got_q.delete(); cmp_q.delete();
    endtask

    task automatic set_fields(input logic [31:0] rm, input logic [7:0] rs, input logic [11:0] so,
                              input logic im, input logic mem, input logic rsh, input logic cin);
        val_rm = rm; val_rs = rs; shift_operand = so;
        imm = im; mem_rw = mem; reg_shift = rsh; carry_in = cin;
    endtask

    task automatic rand_fields();
        logic [7:0] rs_tab [8];
        rs_tab = '{8'd0, 8'd1, 8'd31, 8'd32, 8'd33, 8'd64, 8'd255, 8'd0};
        rs_tab[7] = 8'($urandom);
        val_rm        = ($urandom_range(0, 3) == 0) ? 32'h8000_0001 : $urandom;
        val_rs        = rs_tab[$urandom_range(0, 7)];
        shift_operand = 12'($urandom);
        imm           = ($urandom_range(0, 3) == 0);
        mem_rw        = ($urandom_range(0, 6) == 0);
        reg_shift     = $urandom_range(0, 1) == 1;
        carry_in      = $urandom_range(0, 1) == 1;
    endtask

    task automatic run_single(input logic [31:0] rm, input logic [7:0] rs, input logic [11:0] so,
                              input logic im, input logic mem, input logic rsh, input logic cin,
                              output logic [31:0] v, output logic c, output int lat);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        set_fields(rm, rs, so, im, mem, rsh, cin);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        v = val2; c = shift_carry_out;
    endtask

    task automatic check_single(input string name, input logic [31:0] v, input logic c,
                                input int lat, input logic [31:0] ev, input logic ec);
        n_cmp++;
        if (v !== ev || c !== ec || lat !== DEPTH) begin
            n_fail++;
            $display("FAIL %s: got val2=%h carry=%b lat=%0d, want val2=%h carry=%b lat=%0d",
                     name, v, c, lat, ev, ec, DEPTH);
        end
    endtask

    task automatic compare_sb(input string name, input int want_n);
        n_cmp++;
        if (got_q.size() !== want_n) begin
            n_fail++;
            $display("FAIL %s_count: got %0d results, want %0d", name, got_q.size(), want_n);
        end
        foreach (got_q[i]) begin
            n_cmp++;
            if (got_q[i] !== cmp_q[i]) begin
                n_fail++;
                $display("FAIL %s[%0d]: got %h, want %h", name, i, got_q[i], cmp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        rand_fields();
        tick(); tick();
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_cmp++;
        if (out_valid !== 1'b0 || val2 !== 32'h0 || shift_carry_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b val2=%h c=%b want 0/0/0", out_valid, val2, shift_carry_out);
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_directed();
        logic [31:0] v; logic c; int lat;
        run_single(32'h0, 8'd0, 12'h4FF, 1'b1, 1'b0, 1'b0, 1'b0, v, c, lat);
        check_single("imm_rotate", v, c, lat, 32'hFF00_0000, 1'b1);
        run_single(32'h8000_0001, 8'd0, 12'h020, 1'b0, 1'b0, 1'b0, 1'b0, v, c, lat);
        check_single("lsr32", v, c, lat, 32'h0, 1'b1);
        run_single(32'h8000_0001, 8'd0, 12'h060, 1'b0, 1'b0, 1'b0, 1'b1, v, c, lat);
        check_single("rrx", v, c, lat, 32'hC000_0000, 1'b1);
        run_single(32'h1234_5678, 8'd0, 12'hABC, 1'b1, 1'b1, 1'b0, 1'b1, v, c, lat);
        check_single("mem_offset", v, c, lat, 32'h0000_0ABC, 1'b1);
        run_single(32'h8000_0000, 8'd0, 12'h040, 1'b0, 1'b0, 1'b0, 1'b0, v, c, lat);
        check_single("asr32", v, c, lat, 32'hFFFF_FFFF, 1'b1);
`ifdef VAL2_REG_SHIFT_EN
        run_single(32'h0000_0001, 8'd32, 12'h010, 1'b0, 1'b0, 1'b1, 1'b0, v, c, lat);
        check_single("reg_lsl32", v, c, lat, 32'h0, 1'b1);
        run_single(32'h0000_0001, 8'd33, 12'h010, 1'b0, 1'b0, 1'b1, 1'b0, v, c, lat);
        check_single("reg_lsl33", v, c, lat, 32'h0, 1'b0);
        run_single(32'h8000_0000, 8'd64, 12'h070, 1'b0, 1'b0, 1'b1, 1'b0, v, c, lat);
        check_single("reg_ror64", v, c, lat, 32'h8000_0000, 1'b1);
`else
        run_single(32'h0000_0001, 8'd32, 12'h010, 1'b0, 1'b0, 1'b1, 1'b0, v, c, lat);
        check_single("reg_shift_ignored", v, c, lat, 32'h0000_0001, 1'b0);
`endif
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        logic [32:0] held;
        logic        saw_full;
        int          sent;
        clear_sb();
        sent = 0; saw_full = 1'b0; held = '0;
        for (int cyc = 0; cyc < 40 && (sent < 4 || exp_q.size() > 0 || out_valid); cyc++) begin
            in_valid = (sent < 4);
            rand_fields();
            out_ready = !(cyc >= 2 && cyc <= 4);
            #1;
            if (cyc >= 2 && cyc <= 4 && !in_ready) saw_full = 1'b1;
            if (cyc == 2) begin
                held = {shift_carry_out, val2};
                n_cmp++;
                if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b want 1", out_valid); end
            end
            if (cyc == 3 || cyc == 4) begin
                n_cmp++;
                if ({shift_carry_out, val2} !== held || out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_hold: got %h v=%b, want %h v=1", {shift_carry_out, val2}, out_valid, held);
                end
            end
            tick();
            if (last_acc) sent++;
        end
        n_cmp++;
        if (saw_full !== 1'b1) begin n_fail++; $display("FAIL stall_in_ready: in_ready never fell, want 0 when full"); end
        compare_sb("back_to_back", 4);
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        clear_sb();
        out_ready = 1'b0; in_valid = 1'b1;
        rand_fields(); tick();
        rand_fields(); tick();
        flush = 1'b1;
        rand_fields(); tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        out_ready = 1'b1;
        repeat (6) tick();
        n_cmp++;
        if (got_q.size() !== 0) begin n_fail++; $display("FAIL flush_leak: got %0d results want 0", got_q.size()); end
    endtask

    task automatic test_reset_midstream();
        int k;
        clear_sb();
        out_ready = 1'b0; in_valid = 1'b1;
        rand_fields(); tick();
        in_valid = 1'b0; k = 0;
        while (!out_valid && k < 10) begin tick(); k++; end
        n_cmp++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_setup: out_valid=%b want 1", out_valid); end
        rst = 1'b1; in_valid = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || val2 !== 32'h0 || shift_carry_out !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got v=%b val2=%h c=%b want 0/0/0", out_valid, val2, shift_carry_out);
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_release: in_ready %b want 1", in_ready); end
        out_ready = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (got_q.size() !== 0) begin n_fail++; $display("FAIL midrst_leak: got %0d results want 0", got_q.size()); end
    endtask

    task automatic test_random();
        int sent, cyc;
        clear_sb();
        sent = 0; cyc = 0;
        while ((sent < 300 || exp_q.size() != 0) && cyc < 4000) begin
            in_valid = (sent < 300) && ($urandom_range(0, 99) < 80);
            rand_fields();
            out_ready = ($urandom_range(0, 99) < 70);
            tick();
            if (last_acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (cyc >= 4000) begin n_fail++; $display("FAIL random_timeout: sent %0d pending %0d", sent, exp_q.size()); end
        compare_sb("random", 300);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_fields(32'h0, 8'd0, 12'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        last_acc = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
